// File: rtl/lcd_cmd_sched_if.sv
// Host-side and engine-side handshake signals of the LCD command scheduler.
// The scheduler uses the slave view; the host/engine side uses master.
interface lcd_cmd_sched_if;
   logic [3:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy;
   logic       done;

   modport slave (
      input  host_cmd, host_valid, busy, done,
      output host_ready, cmd, cmd_valid
   );

   modport master (
      output host_cmd, host_valid, busy, done,
      input  host_ready, cmd, cmd_valid
   );
endinterface

// File: rtl/lcd_cmd_sched.sv
// Buffers host commands in a FIFO and issues them one at a time to LCD_CTRL,
// following its busy handshake and reporting frame completion after write-back.
module lcd_cmd_sched #(
   parameter int          DEPTH     = 8,
   parameter int          ACK_WAIT  = 2,
   parameter logic [3:0]  WRITE_CMD = 4'd0
) (
   input  logic                   clk,
   input  logic                   reset,
   lcd_cmd_sched_if.slave         bus,
   output logic                   sched_done,
   output logic [7:0]             issued_cnt,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int AW    = $clog2(ACK_WAIT + 1);
   localparam logic [AW-1:0]    ACK_LAST = AW'(ACK_WAIT - 1);
   localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      ACK,
      WAIT,
      DONEW,
      FIN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [3:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [3:0]       cmd_q;
   logic [AW-1:0]    ack_cnt;
   logic             done_seen;
   logic             push;
   logic             pop;
   logic             is_write;
   logic             done_hit;
   state_t           exit_state;

   assign push     = bus.host_valid && bus.host_ready;
   assign is_write = (cmd_q == WRITE_CMD);
   assign done_hit = done_seen || bus.done;
   // A completed write goes straight to FIN if done already showed up.
   assign exit_state = is_write ? (done_hit ? FIN : DONEW) : IDLE;

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE, FIN: begin
            if ((count != '0) && !bus.busy) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = ACK;
         ACK: begin
            if (bus.busy)
               state_next = WAIT;
            else if (ack_cnt == ACK_LAST)
               state_next = exit_state;
         end
         WAIT: begin
            if (!bus.busy)
               state_next = exit_state;
         end
         DONEW: begin
            if (bus.done)
               state_next = FIN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cmd_q      <= 4'd0;
         ack_cnt    <= '0;
         done_seen  <= 1'b0;
         issued_cnt <= 8'd0;
      end else begin
         state <= state_next;
         if (pop)
            cmd_q <= mem[rd_ptr];
         if (state == ISSUE) begin
            ack_cnt    <= '0;
            done_seen  <= 1'b0;
            issued_cnt <= issued_cnt + 8'd1;
         end else begin
            if (state == ACK)
               ack_cnt <= ack_cnt + 1'b1;
            if ((state == ACK || state == WAIT) && is_write && bus.done)
               done_seen <= 1'b1;
         end
      end
   end

   // Storage needs no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.host_cmd;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.host_ready = (count != FULL_LVL);
   assign bus.cmd        = cmd_q;
   assign bus.cmd_valid  = (state == ISSUE);
   assign sched_done     = (state == FIN);
   assign fifo_level     = count;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scoreboard bench for lcd_cmd_sched: pushes record expected issues in a queue,
// a monitor pops and compares on every cmd_valid strobe.
module tb_lcd_cmd_sched;

   logic       clk;
   logic       reset;
   logic       sched_done;
   logic [7:0] issued_cnt;
   logic [3:0] fifo_level;

   lcd_cmd_sched_if ifc ();

   lcd_cmd_sched #(.DEPTH(8), .ACK_WAIT(2), .WRITE_CMD(4'd0)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (ifc.slave),
      .sched_done (sched_done),
      .issued_cnt (issued_cnt),
      .fifo_level (fifo_level)
   );

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] exp_q [$];
   bit         engine_auto = 1'b1;
   bit         skip5 = 1'b0;
   bit         done_early = 1'b0;
   int         cycle = 0;
   int         last_strobe = 0;
   int         prev_strobe = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present one command and hold it until the FIFO takes it.
   task automatic applyStimulus(input logic [3:0] c);
      int n = 0;
      ifc.host_cmd   = c;
      ifc.host_valid = 1'b1;
      @(negedge clk);
      while (!ifc.host_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.host_ready)
         checkOutput("push_timeout", ifc.host_ready, 1);
      else
         exp_q.push_back(c);
      @(posedge clk);
      #1;
      ifc.host_valid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", exp_q.size(), 0);
   endtask

   task automatic waitSchedDone(input int budget);
      int n = 0;
      while (!sched_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sched_done_set", sched_done, 1);
   endtask

   // Engine model: busy for 3 cycles per command, done 2 cycles after a write.
   initial begin
      logic [3:0] c;
      ifc.busy = 1'b0;
      ifc.done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (engine_auto && ifc.cmd_valid && !(skip5 && ifc.cmd == 4'h5)) begin
            c = ifc.cmd;
            ifc.busy = 1'b1;
            if (done_early && c == 4'h0) begin
               @(posedge clk); #1;
               @(posedge clk); #1;
               ifc.done = 1'b1;
               @(posedge clk); #1;
               ifc.done = 1'b0;
               ifc.busy = 1'b0;
            end else begin
               repeat (3) begin
                  @(posedge clk); #1;
               end
               ifc.busy = 1'b0;
               if (c == 4'h0) begin
                  repeat (2) begin
                     @(posedge clk); #1;
                  end
                  ifc.done = 1'b1;
                  @(posedge clk); #1;
                  ifc.done = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: order, strobe spacing, issue-while-busy and issue count.
   initial begin
      logic [7:0] model_cnt;
      logic [3:0] e;
      bit         prev_valid;
      bit         prev_busy;
      bit         cnt_check;
      model_cnt  = 8'd0;
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
      cnt_check  = 1'b0;
      forever begin
         @(negedge clk);
         cycle++;
         if (!reset) begin
            model_cnt  = 8'd0;
            prev_valid = 1'b0;
            cnt_check  = 1'b0;
         end else begin
            if (cnt_check) begin
               checkOutput("issued_cnt", issued_cnt, model_cnt);
               cnt_check = 1'b0;
            end
            if (ifc.cmd_valid) begin
               checkOutput("no_back_to_back", prev_valid, 0);
               checkOutput("not_busy_before_issue", prev_busy, 0);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL spurious_issue: got cmd %0h, expected no issue", ifc.cmd);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("cmd_order", ifc.cmd, e);
               end
               model_cnt   = model_cnt + 8'd1;
               cnt_check   = 1'b1;
               prev_strobe = last_strobe;
               last_strobe = cycle;
            end
            prev_valid = ifc.cmd_valid;
         end
         prev_busy = ifc.busy;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset          = 1'b0;
      ifc.host_cmd   = 4'h0;
      ifc.host_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cmd", ifc.cmd, 0);
      checkOutput("rst_cmd_valid", ifc.cmd_valid, 0);
      checkOutput("rst_sched_done", sched_done, 0);
      checkOutput("rst_issued_cnt", issued_cnt, 0);
      checkOutput("rst_fifo_level", fifo_level, 0);
      checkOutput("rst_host_ready", ifc.host_ready, 1);
      reset = 1'b1;
      @(posedge clk); #1;

      $display("[TB] basic sequence 1,2,0");
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'h0);
      waitSchedDone(100);
      checkOutput("t1_issued", issued_cnt, 3);
      checkOutput("t1_cmd_hold", ifc.cmd, 0);
      checkOutput("t1_drained", exp_q.size(), 0);

      $display("[TB] fill FIFO with busy held");
      @(posedge clk); #1;
      engine_auto = 1'b0;
      ifc.busy    = 1'b1;
      for (int i = 3; i <= 10; i++)
         applyStimulus(4'(i));
      @(negedge clk);
      checkOutput("t2_level_full", fifo_level, 8);
      checkOutput("t2_host_ready_full", ifc.host_ready, 0);
      checkOutput("t2_fin_stall", sched_done, 1);
      @(posedge clk); #1;
      fork
         applyStimulus(4'hB);
         begin
            repeat (3) @(negedge clk);
            checkOutput("t2_ninth_held", fifo_level, 8);
            @(posedge clk); #1;
            engine_auto = 1'b1;
            ifc.busy    = 1'b0;
         end
      join
      waitDrain(300);
      repeat (8) @(negedge clk);
      checkOutput("t2_level_empty", fifo_level, 0);
      checkOutput("t2_sched_done_clr", sched_done, 0);
      checkOutput("t2_issued", issued_cnt, 12);

      $display("[TB] ack timeout for cmd 5");
      @(posedge clk); #1;
      skip5 = 1'b1;
      applyStimulus(4'h5);
      applyStimulus(4'h6);
      waitDrain(100);
      repeat (10) @(negedge clk);
      checkOutput("t3_issue_spacing", last_strobe - prev_strobe, 4);
      checkOutput("t3_issued", issued_cnt, 14);
      skip5 = 1'b0;

      $display("[TB] done during WAIT of write");
      @(posedge clk); #1;
      done_early = 1'b1;
      applyStimulus(4'h0);
      n = 0;
      while (!ifc.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (ifc.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t4_busy_fell", ifc.busy, 0);
      @(negedge clk);
      checkOutput("t4_fin_after_wait", sched_done, 1);
      checkOutput("t4_issued", issued_cnt, 15);
      done_early = 1'b0;

      $display("[TB] reset mid-WAIT");
      @(posedge clk); #1;
      applyStimulus(4'h7);
      applyStimulus(4'h8);
      applyStimulus(4'h9);
      applyStimulus(4'hA);
      @(negedge clk);
      checkOutput("t5_level_before", fifo_level, 3);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("t5_fifo_level", fifo_level, 0);
      checkOutput("t5_issued_cnt", issued_cnt, 0);
      checkOutput("t5_host_ready", ifc.host_ready, 1);
      checkOutput("t5_cmd", ifc.cmd, 0);
      checkOutput("t5_cmd_valid", ifc.cmd_valid, 0);
      checkOutput("t5_sched_done", sched_done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("t5_idle_level", fifo_level, 0);
      checkOutput("t5_idle_issued", issued_cnt, 0);

      $display("[TB] 256 commands");
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++)
         applyStimulus(4'((i % 15) + 1));
      waitDrain(400);
      repeat (10) @(negedge clk);
      checkOutput("t6_issued_wrap", issued_cnt, 0);
      checkOutput("t6_level", fifo_level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
